// File: rtl/mips_cpu_regfile_pkg.sv
// Shared constants and types for the multi-port MIPS register file.
// The write-port struct is sized for the default geometry.
package mips_cpu_regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int AW_DEF       = $clog2(NUM_REGS_DEF);
   localparam int V0_IDX       = 2;
   localparam int NUM_WR       = 2;

   typedef struct packed {
      logic                  en;
      logic [AW_DEF-1:0]     addr;
      logic [DATA_W_DEF-1:0] data;
   } wr_port_t;

   // A request is legal unless it targets the hardwired zero register.
   function automatic logic port_legal(input logic en, input logic addr_is_zero,
                                       input logic zero_reg);
      return en && !(zero_reg && addr_is_zero);
   endfunction

endpackage

// File: rtl/mips_cpu_regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer and
// keeps an incrementally maintained count of them.
module mips_cpu_regfile_scoreboard
   import mips_cpu_regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   input  logic [NUM_WR-1:0]        wr_ok,
   input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
   output logic [NUM_REGS-1:0]      busy,
   output logic [AW:0]              pend_cnt
);

   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic              iss_ok;
   logic              rise;
   logic [NUM_WR-1:0] fall;
   logic [AW:0]       pend_nxt;

   assign iss_ok = port_legal(iss_en, iss_addr == '0, ZERO_REG);

   // An issue only counts when the target was idle; a write only counts when
   // it clears a busy bit the same-cycle issue is not re-setting, and two
   // writes to one register clear it once.
   assign rise    = iss_ok && !busy[iss_addr];
   assign fall[0] = wr_ok[0] && busy[wr_addr[0]] &&
                    !(iss_ok && iss_addr == wr_addr[0]);
   assign fall[1] = wr_ok[1] && busy[wr_addr[1]] &&
                    !(iss_ok && iss_addr == wr_addr[1]) &&
                    !(wr_ok[0] && wr_addr[0] == wr_addr[1]);

   always_comb begin
      pend_nxt = pend_cnt;
      if (rise)    pend_nxt = pend_nxt + ONE;
      if (fall[0]) pend_nxt = pend_nxt - ONE;
      if (fall[1]) pend_nxt = pend_nxt - ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) busy[wr_addr[p]] <= 1'b0;
         end
         if (iss_ok) busy[iss_addr] <= 1'b1;
         pend_cnt <= pend_nxt;
      end
   end

   a_pend_matches_busy : assert property (
      @(posedge clk) disable iff (reset) int'(pend_cnt) == $countones(busy));

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-port register file with two write ports, optional same-cycle
// write-to-read forwarding and a producer scoreboard.
module mips_cpu_regfile_mp
   import mips_cpu_regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
   input  logic                         iss_en,
   input  logic [AW-1:0]                iss_addr,
   output logic [DATA_W-1:0]            v0_data,
   output logic [AW:0]                  pend_cnt
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_WR-1:0]   wr_ok;
   logic [NUM_REGS-1:0] busy;

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_ok
      assign wr_ok[p] = port_legal(wr_en[p], wr_addr[p] == '0, ZERO_REG);
   end

   // Port 1 is applied last so it wins a same-address conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) regs[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   mips_cpu_regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_ok    (wr_ok),
      .wr_addr  (wr_addr),
      .busy     (busy),
      .pend_cnt (pend_cnt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [DATA_W-1:0] data_c;
      logic              busy_c;

      always_comb begin
         data_c = regs[rd_addr[i]];
         busy_c = busy[rd_addr[i]];
         if (ZERO_REG && rd_addr[i] == '0) data_c = '0;
         // Illegal writes never forward, so register 0 stays zero here too.
         if (BYPASS) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_ok[p] && wr_addr[p] == rd_addr[i]) begin
                  data_c = wr_data[p];
                  busy_c = 1'b0;
               end
            end
         end
      end

      assign rd_data[i] = data_c;
      assign rd_busy[i] = busy_c;
   end

   assign v0_data = regs[AW'(V0_IDX)];

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Directed bench for the register file: a behavioural model checked every
// cycle against a bypassing and a non-bypassing instance, plus pinned literals.
module tb_mips_cpu_regfile_mp;
   import mips_cpu_regfile_pkg::*;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NRD-1:0][AW-1:0] rd_addr;
   logic [NRD-1:0][DW-1:0] rd_data, rd_data_nb;
   logic [NRD-1:0]         rd_busy, rd_busy_nb;
   logic [1:0]             wr_en;
   logic [1:0][AW-1:0]     wr_addr;
   logic [1:0][DW-1:0]     wr_data;
   logic                   iss_en;
   logic [AW-1:0]          iss_addr;
   logic [DW-1:0]          v0_data, v0_data_nb;
   logic [AW:0]            pend_cnt, pend_cnt_nb;
   wr_port_t               wp0, wp1;

   assign wr_en   = {wp1.en, wp0.en};
   assign wr_addr = {wp1.addr, wp0.addr};
   assign wr_data = {wp1.data, wp0.data};

   always #5 clk = ~clk;

   mips_cpu_regfile_mp u_dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .v0_data(v0_data), .pend_cnt(pend_cnt)
   );

   mips_cpu_regfile_mp #(.BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .v0_data(v0_data_nb), .pend_cnt(pend_cnt_nb)
   );

   // Behavioural model: plain register array and busy flags.
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];
   bit            m_valid;
   int            n_cmp, n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit fwd_hit(input wr_port_t w, input logic [AW-1:0] a);
      return w.en && w.addr == a && a != '0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int i, input bit byp);
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      a = rd_addr[i];
      v = (a == '0) ? '0 : m_regs[a];
      if (byp && fwd_hit(wp0, a)) v = wp0.data;
      if (byp && fwd_hit(wp1, a)) v = wp1.data;
      return v;
   endfunction

   function automatic logic exp_busy(input int i, input bit byp);
      logic [AW-1:0] a;
      a = rd_addr[i];
      if (byp && (fwd_hit(wp0, a) || fwd_hit(wp1, a))) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int busy_count();
      int c = 0;
      for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
      return c;
   endfunction

   task automatic model_compare();
      if (!m_valid) return;
      for (int i = 0; i < NRD; i++) begin
         chk($sformatf("rd_data[%0d]", i), rd_data[i], exp_rd(i, 1'b1));
         chk($sformatf("rd_busy[%0d]", i), 32'(rd_busy[i]), 32'(exp_busy(i, 1'b1)));
         chk($sformatf("nb_rd_data[%0d]", i), rd_data_nb[i], exp_rd(i, 1'b0));
         chk($sformatf("nb_rd_busy[%0d]", i), 32'(rd_busy_nb[i]), 32'(exp_busy(i, 1'b0)));
      end
      chk("v0_data", v0_data, m_regs[2]);
      chk("nb_v0_data", v0_data_nb, m_regs[2]);
      chk("pend_cnt", 32'(pend_cnt), 32'(busy_count()));
      chk("nb_pend_cnt", 32'(pend_cnt_nb), 32'(busy_count()));
   endtask

   task automatic model_update();
      if (reset) begin
         for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
         end
         m_valid = 1'b1;
      end else begin
         if (wp0.en && wp0.addr != '0) begin
            m_regs[wp0.addr] = wp0.data;
            m_busy[wp0.addr] = 1'b0;
         end
         if (wp1.en && wp1.addr != '0) begin
            m_regs[wp1.addr] = wp1.data;
            m_busy[wp1.addr] = 1'b0;
         end
         if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
      end
   endtask

   function automatic wr_port_t mk_wr(input int a, input logic [31:0] d);
      return '{en: 1'b1, addr: AW'(a), data: d};
   endfunction

   task automatic idle();
      wp0      = '0;
      wp1      = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic issue(input int a);
      iss_en   = 1'b1;
      iss_addr = AW'(a);
   endtask

   task automatic settle();
      @(negedge clk);
      model_compare();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
      idle();
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      m_valid = 1'b0;
      for (int r = 0; r < NR; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
      reset   = 1'b1;
      rd_addr = '0;
      idle();
      advance();
      advance();

      reset      = 1'b0;
      rd_addr[0] = 5;
      rd_addr[1] = 7;
      settle();
      chk("reset_rd_data0", rd_data[0], 32'h0);
      chk("reset_rd_busy0", 32'(rd_busy[0]), 32'h0);
      chk("reset_v0", v0_data, 32'h0);
      chk("reset_pend", 32'(pend_cnt), 32'h0);
      advance();

      wp0 = mk_wr(5, 32'hDEADBEEF);
      cyc();
      settle();
      chk("wr5_read", rd_data[0], 32'hDEADBEEF);
      chk("wr5_v0", v0_data, 32'h0);
      advance();

      wp0 = mk_wr(7, 32'h33);
      cyc();
      wp0 = mk_wr(7, 32'h11);
      wp1 = mk_wr(7, 32'h22);
      settle();
      chk("conflict_bypass", rd_data[1], 32'h22);
      chk("conflict_nobypass", rd_data_nb[1], 32'h33);
      advance();
      settle();
      chk("conflict_after", rd_data[1], 32'h22);
      chk("conflict_after_nb", rd_data_nb[1], 32'h22);
      advance();

      wp0 = mk_wr(0, 32'hFFFFFFFF);
      issue(0);
      rd_addr[0] = 0;
      settle();
      chk("r0_same_cycle", rd_data[0], 32'h0);
      advance();
      settle();
      chk("r0_after", rd_data[0], 32'h0);
      chk("r0_busy", 32'(rd_busy[0]), 32'h0);
      chk("r0_pend", 32'(pend_cnt), 32'h0);
      advance();

      issue(3);
      cyc();
      issue(4);
      rd_addr[0] = 3;
      rd_addr[1] = 4;
      cyc();
      settle();
      chk("iss34_pend", 32'(pend_cnt), 32'd2);
      chk("iss34_busy0", 32'(rd_busy[0]), 32'h1);
      chk("iss34_busy1", 32'(rd_busy[1]), 32'h1);
      advance();
      wp0 = mk_wr(3, 32'h300);
      wp1 = mk_wr(4, 32'h400);
      settle();
      chk("wr34_fwd_busy", 32'(rd_busy[0]), 32'h0);
      chk("wr34_fwd_data", rd_data[0], 32'h300);
      chk("wr34_nb_busy", 32'(rd_busy_nb[0]), 32'h1);
      advance();
      settle();
      chk("wr34_pend", 32'(pend_cnt), 32'h0);
      chk("wr34_data1", rd_data[1], 32'h400);
      advance();

      issue(9);
      wp0 = mk_wr(9, 32'h900);
      rd_addr[0] = 9;
      cyc();
      settle();
      chk("iss_wins_busy", 32'(rd_busy[0]), 32'h1);
      chk("iss_wins_pend", 32'(pend_cnt), 32'h1);
      chk("iss_wins_data", rd_data[0], 32'h900);
      advance();

      wp0 = mk_wr(9, 32'h901);
      wp1 = mk_wr(9, 32'h902);
      cyc();
      settle();
      chk("dup_wr_pend", 32'(pend_cnt), 32'h0);
      chk("dup_wr_data", rd_data[0], 32'h902);
      advance();

      issue(10);
      cyc();
      issue(10);
      cyc();
      settle();
      chk("reissue_pend", 32'(pend_cnt), 32'h1);
      advance();
      issue(11);
      wp1 = mk_wr(10, 32'hA0);
      cyc();
      settle();
      chk("swap_pend", 32'(pend_cnt), 32'h1);
      advance();

      wp0 = mk_wr(2, 32'hAA);
      cyc();
      issue(2);
      cyc();
      issue(6);
      rd_addr[0] = 6;
      cyc();
      settle();
      chk("pre_reset_v0", v0_data, 32'hAA);
      chk("pre_reset_pend", 32'(pend_cnt), 32'd3);
      advance();
      reset = 1'b1;
      wp1   = mk_wr(2, 32'hBB);
      issue(12);
      cyc();
      reset = 1'b0;
      wp0   = mk_wr(6, 32'h66);
      cyc();
      settle();
      chk("post_reset_pend", 32'(pend_cnt), 32'h0);
      chk("post_reset_v0", v0_data, 32'h0);
      chk("post_reset_data", rd_data[0], 32'h66);
      advance();

      // Deterministic mixed traffic sweeping addresses across both ports.
      for (int k = 0; k < 48; k++) begin
         rd_addr[0] = AW'((k * 7) % NR);
         rd_addr[1] = AW'((k * 3 + 1) % NR);
         if (k % 3 != 2) issue((k * 5) % NR);
         if (k % 2 == 1) wp0 = mk_wr((k * 7) % NR, 32'h1000 + k);
         if (k % 4 == 3) wp1 = mk_wr((k * 5 + 10) % NR, 32'h2000 + k);
         cyc();
      end
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_cpu_regfile_mp.md
MIPS_CPU_REGFILE_MP -- requirements
Module: mips_cpu_regfile_mp

Interface
REQ-001 SHALL take parameter DATA_W, default 32: width of each register in bits.
REQ-002 SHALL take parameter NUM_REGS, default 32: register count, power of two, at least 4; AW = log2(NUM_REGS).
REQ-003 SHALL take parameter NUM_RD, default 2, range 1..4: number of read ports.
REQ-004 SHALL take parameter ZERO_REG, default 1: when 1, register 0 reads 0 and is never written or marked busy.
REQ-005 SHALL take parameter BYPASS, default 1: when 1, write-to-read forwarding occurs in the same cycle.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 rd_addr  in  NUM_RD x AW  read addresses.
REQ-009 rd_data  out  NUM_RD x DATA_W  read data, combinational.
REQ-010 rd_busy  out  NUM_RD  addressed register has an outstanding producer.
REQ-011 wr_en  in  2  write enable for write port 0 and write port 1.
REQ-012 wr_addr  in  2 x AW  write addresses.
REQ-013 wr_data  in  2 x DATA_W  write data.
REQ-014 iss_en  in  1  marks iss_addr busy (producer issued).
REQ-015 iss_addr  in  AW  destination being issued.
REQ-016 v0_data  out  DATA_W  register 2 contents, registered state, no bypass.
REQ-017 pend_cnt  out  AW+1  number of busy registers.

Function
REQ-018 Read: rd_data[i] SHALL equal reg[rd_addr[i]], except that rd_data[i] SHALL be 0 when ZERO_REG=1 and rd_addr[i]=0.
REQ-019 Bypass: when BYPASS=1 and wr_en[p] is high with wr_addr[p]=rd_addr[i] and the write is legal, rd_data[i] SHALL return wr_data[p] in the same cycle; if both ports match, port 1 is forwarded.
REQ-020 Write: each legal enabled write port SHALL update its register at the next rising edge; a write to address 0 when ZERO_REG=1 is illegal and dropped.
REQ-021 Write conflict: if both ports write the same address in one cycle, the register SHALL take wr_data[1].
REQ-022 Scoreboard: iss_en SHALL set busy[iss_addr] at the next edge; iss_addr=0 with ZERO_REG=1 is ignored.
REQ-023 A legal write SHALL clear busy[wr_addr] at the next edge.
REQ-024 If an issue and a write target the same address in the same cycle, busy SHALL remain 1 (the issue wins).
REQ-025 Issuing to an already-busy register SHALL leave busy at 1 and leave pend_cnt unchanged.
REQ-026 rd_busy[i] SHALL equal busy[rd_addr[i]], forced to 0 when a legal same-cycle write to that address is present and BYPASS=1.
REQ-027 pend_cnt SHALL be updated incrementally each edge by +1 per 0->1 busy transition and -1 per 1->0 busy transition, with a maximum net change of -2..+1 per cycle; it SHALL always equal popcount(busy).

Reset
REQ-028 While reset is high at a rising edge, all registers, all busy bits and pend_cnt SHALL become 0; writes and issues in that cycle are discarded.
REQ-029 After reset, all rd_data, rd_busy, v0_data and pend_cnt outputs SHALL read 0 until the next write or issue.
REQ-030 Reset asserted mid-operation SHALL abandon all outstanding producers; a later write to a formerly busy register SHALL NOT decrement pend_cnt below 0.

Structure
REQ-031 Package mips_cpu_regfile_pkg SHALL hold the default-width constants, the register-2 (v0) index constant and a write-port struct {en, addr, data}.
REQ-032 Sub-module mips_cpu_regfile_scoreboard SHALL own the busy bits and pend_cnt; the data array and forwarding SHALL stay in the top level.
REQ-033 The design SHALL be a single clock domain with no latches, and SHALL be synthesisable for any legal parameter set.

Verification
REQ-034 Reset, then write reg5=0xDEADBEEF on port 0 -> the next cycle, rd_addr[0]=5 reads 0xDEADBEEF and v0_data=0.
REQ-035 Same-cycle write reg7=0x11 on port 0 and reg7=0x22 on port 1 with rd_addr[1]=7 -> rd_data[1]=0x22 in that cycle and reg7=0x22 afterwards; with BYPASS=0, rd_data[1] shows the old value in that cycle.
REQ-036 Write reg0=0xFFFFFFFF and issue to reg0 with ZERO_REG=1 -> rd_data=0, busy 0, pend_cnt=0.
REQ-037 Issue reg3 then reg4 -> pend_cnt=2 and rd_busy=1 for both; write reg3 and reg4 together -> pend_cnt=0 next cycle; issue reg9 together with a write to reg9 -> busy stays 1 and pend_cnt=1.
REQ-038 Issue reg2 and reg6, assert reset, then write reg6 -> pend_cnt stays 0 and v0_data=0.
